// File: rtl/src_operand_sequencer.sv
// src_operand_sequencer: serialises SGPR/VGPR source reads and literal capture per instruction; optional stall counter via SRC_SEQ_STALL_CNT_EN
module src_operand_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [5:0]  dec_wfid,
  input  logic [11:0] dec_src0,
  input  logic [11:0] dec_src1,
  input  logic [11:0] dec_src2,
  input  logic [1:0]  dec_src_count,
  input  logic [2:0]  dec_src_wide,
  input  logic        dec_literal_required,
  output logic        sgpr_rd_en,
  output logic [8:0]  sgpr_rd_addr,
  input  logic        sgpr_rd_gnt,
  output logic        vgpr_rd_en,
  output logic [9:0]  vgpr_rd_addr,
  input  logic        vgpr_rd_gnt,
  input  logic        lit_valid,
  input  logic [31:0] lit_data,
  output logic        lit_ready,
  output logic        seq_done,
  output logic [5:0]  seq_wfid,
  output logic [31:0] seq_literal,
  output logic [15:0] stall_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_n;
  logic [11:0] dsrc [3];
  logic [11:0] src [3];
  logic [2:0] wide, sgpr_pend, vgpr_pend, sgpr_acc, vgpr_acc, sgpr_clr, vgpr_clr, sgpr_pend_n, vgpr_pend_n;
  logic lit_pend, sgpr_half, vgpr_half, sgpr_fire, vgpr_fire, lit_fire, sgpr_last, vgpr_last, accept;
  logic [1:0] sidx, vidx;
  assign dsrc[0] = dec_src0;
  assign dsrc[1] = dec_src1;
  assign dsrc[2] = dec_src2;
  for (genvar i = 0; i < 3; i++) begin : g_acc
    assign sgpr_acc[i] = (2'(i) < dec_src_count) && dsrc[i][11:9] == 3'b110;
    assign vgpr_acc[i] = (2'(i) < dec_src_count) && dsrc[i][11:10] == 2'b10;
  end
  assign accept = dec_ready && dec_valid;
  // lowest pending operand per port and which pend bits retire this cycle
  always_comb begin
    sidx = sgpr_pend[0] ? 2'd0 : sgpr_pend[1] ? 2'd1 : 2'd2;
    vidx = vgpr_pend[0] ? 2'd0 : vgpr_pend[1] ? 2'd1 : 2'd2;
    sgpr_fire = sgpr_rd_en && sgpr_rd_gnt;
    vgpr_fire = vgpr_rd_en && vgpr_rd_gnt;
    lit_fire = lit_ready && lit_valid;
    sgpr_last = !wide[sidx] || sgpr_half;
    vgpr_last = !wide[vidx] || vgpr_half;
    sgpr_clr = (sgpr_fire && sgpr_last) ? 3'b001 << sidx : 3'b000;
    vgpr_clr = (vgpr_fire && vgpr_last) ? 3'b001 << vidx : 3'b000;
    sgpr_pend_n = sgpr_pend & ~sgpr_clr;
    vgpr_pend_n = vgpr_pend & ~vgpr_clr;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: leave ISSUE once nothing is pending after this cycle's progress
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = !dec_valid ? IDLE : (|{sgpr_acc, vgpr_acc, dec_literal_required}) ? ISSUE : DONE;
      ISSUE: state_n = (|{sgpr_pend_n, vgpr_pend_n, lit_pend && !lit_fire}) ? ISSUE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // request/ready outputs decoded from registered state; addresses zero when idle
  always_comb begin
    dec_ready = state == IDLE;
    seq_done = state == DONE;
    sgpr_rd_en = state == ISSUE && |sgpr_pend;
    vgpr_rd_en = state == ISSUE && |vgpr_pend;
    lit_ready = state == ISSUE && lit_pend;
    sgpr_rd_addr = sgpr_rd_en ? src[sidx][8:0] + {8'd0, sgpr_half} : 9'd0;
    vgpr_rd_addr = vgpr_rd_en ? src[vidx][9:0] + {9'd0, vgpr_half} : 10'd0;
  end
  // operand capture on accept, pend/half retirement and literal capture while issuing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      src <= '{default: 12'd0};
      wide <= '0;
      sgpr_pend <= '0;
      vgpr_pend <= '0;
      lit_pend <= 1'b0;
      sgpr_half <= 1'b0;
      vgpr_half <= 1'b0;
      seq_wfid <= '0;
      seq_literal <= '0;
    end else if (accept) begin
      src <= dsrc;
      wide <= dec_src_wide;
      sgpr_pend <= sgpr_acc;
      vgpr_pend <= vgpr_acc;
      lit_pend <= dec_literal_required;
      sgpr_half <= 1'b0;
      vgpr_half <= 1'b0;
      seq_wfid <= dec_wfid;
      seq_literal <= '0;
    end else begin
      sgpr_pend <= sgpr_pend_n;
      vgpr_pend <= vgpr_pend_n;
      sgpr_half <= sgpr_fire ? !sgpr_last : sgpr_half;
      vgpr_half <= vgpr_fire ? !vgpr_last : vgpr_half;
      lit_pend <= lit_pend && !lit_fire;
      seq_literal <= lit_fire ? lit_data : seq_literal;
    end
`ifdef SRC_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;
  // saturating count of issue cycles where any port is waiting
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_q <= '0;
    else if (((sgpr_rd_en && !sgpr_rd_gnt) || (vgpr_rd_en && !vgpr_rd_gnt) || (lit_ready && !lit_valid)) && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif
endmodule
